cond_flag_unit: RTL and testbench

Conditional-execution stage sitting directly downstream of the ALU flag generator in the processor datapath. It captures the ALU's N/Z/C/V flags into an architectural flag register under per-group write enables and evaluates each instruction's 4-bit ARM condition field against the registered flags. It gates the instruction's PC-write, register-write and memory-write strobes. It also keeps a one-entry saved copy of the flags for exception entry/return and counts executed and skipped instructions.

---
 rtl/cond_flag_unit.sv | 102 ++++++++++
 tb/tb_cond_flag_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cond_flag_unit.sv
// Conditional-execution stage: holds the architectural N/Z/C/V flags, evaluates the
// ARM condition field against them, gates write strobes and counts executed/skipped ops.
module cond_flag_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   input  logic [3:0]       cond,
   input  logic [3:0]       alu_flags,
   input  logic [1:0]       flag_w,
   input  logic             pcs,
   input  logic             reg_w,
   input  logic             mem_w,
   input  logic             no_write,
   input  logic             save,
   input  logic             restore,
   output logic             cond_ex,
   output logic             pcs_o,
   output logic             reg_w_o,
   output logic             mem_w_o,
   output logic [3:0]       flags_q,
   output logic [3:0]       saved_q,
   output logic [CNT_W-1:0] exec_cnt,
   output logic [CNT_W-1:0] skip_cnt
);

   typedef enum logic [3:0] {
      C_EQ = 4'b0000, C_NE = 4'b0001, C_CS = 4'b0010, C_CC = 4'b0011,
      C_MI = 4'b0100, C_PL = 4'b0101, C_VS = 4'b0110, C_VC = 4'b0111,
      C_HI = 4'b1000, C_LS = 4'b1001, C_GE = 4'b1010, C_LT = 4'b1011,
      C_GT = 4'b1100, C_LE = 4'b1101, C_AL = 4'b1110, C_NV = 4'b1111
   } cond_e;

   logic n_f, z_f, c_f, v_f;
   logic exe;

   assign {n_f, z_f, c_f, v_f} = flags_q;

   // Decode looks only at the registered flags; there is deliberately no alu_flags bypass.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      cond_ex = 1'b1;
      case (cond_e'(cond))
         C_EQ:    cond_ex = z_f;
         C_NE:    cond_ex = !z_f;
         C_CS:    cond_ex = c_f;
         C_CC:    cond_ex = !c_f;
         C_MI:    cond_ex = n_f;
         C_PL:    cond_ex = !n_f;
         C_VS:    cond_ex = v_f;
         C_VC:    cond_ex = !v_f;
         C_HI:    cond_ex = c_f && !z_f;
         C_LS:    cond_ex = !c_f || z_f;
         C_GE:    cond_ex = (n_f == v_f);
         C_LT:    cond_ex = (n_f != v_f);
         C_GT:    cond_ex = !z_f && (n_f == v_f);
         C_LE:    cond_ex = z_f || (n_f != v_f);
         C_AL:    cond_ex = 1'b1;
         C_NV:    cond_ex = 1'b1;
         default: cond_ex = 1'b1;
      endcase
   end

   assign exe     = instr_valid && cond_ex;
   assign pcs_o   = exe && pcs;
   assign reg_w_o = exe && reg_w && !no_write;
   assign mem_w_o = exe && mem_w;

   // Restore wins over any flag write; save always captures the pre-edge flags,
   // so save+restore together swap the two registers.
   // NOTE: non-blocking assignments make both registers read their old values here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags_q <= '0;
         saved_q <= '0;
      end else begin
         if (save) saved_q <= flags_q;
         if (restore) begin
            flags_q <= saved_q;
         end else begin
            if (exe && flag_w[1]) flags_q[3:2] <= alu_flags[3:2];
            if (exe && flag_w[0]) flags_q[1:0] <= alu_flags[1:0];
         end
      end
   end

   // Saturating counters: stop at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exec_cnt <= '0;
         skip_cnt <= '0;
      end else if (instr_valid) begin
         if (cond_ex) begin
            if (exec_cnt != '1) exec_cnt <= exec_cnt + 1'b1;
         end else begin
            if (skip_cnt != '1) skip_cnt <= skip_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed bench for cond_flag_unit: hand-computed expectations, plus a CNT_W=2
// instance to exercise counter saturation.
module tb_cond_flag_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic [3:0]  cond;
   logic [3:0]  alu_flags;
   logic [1:0]  flag_w;
   logic        pcs, reg_w, mem_w, no_write, save, restore;
   logic        cond_ex, pcs_o, reg_w_o, mem_w_o;
   logic [3:0]  flags_q, saved_q;
   logic [15:0] exec_cnt, skip_cnt;

   logic        sat_valid;
   logic        s_cond_ex, s_pcs_o, s_reg_w_o, s_mem_w_o;
   logic [3:0]  s_flags_q, s_saved_q;
   logic [1:0]  s_exec_cnt, s_skip_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cond_flag_unit #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .cond(cond),
      .alu_flags(alu_flags), .flag_w(flag_w), .pcs(pcs), .reg_w(reg_w),
      .mem_w(mem_w), .no_write(no_write), .save(save), .restore(restore),
      .cond_ex(cond_ex), .pcs_o(pcs_o), .reg_w_o(reg_w_o), .mem_w_o(mem_w_o),
      .flags_q(flags_q), .saved_q(saved_q), .exec_cnt(exec_cnt), .skip_cnt(skip_cnt)
   );

   cond_flag_unit #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .instr_valid(sat_valid), .cond(4'b1110),
      .alu_flags(4'b0000), .flag_w(2'b00), .pcs(1'b0), .reg_w(1'b0),
      .mem_w(1'b0), .no_write(1'b0), .save(1'b0), .restore(1'b0),
      .cond_ex(s_cond_ex), .pcs_o(s_pcs_o), .reg_w_o(s_reg_w_o), .mem_w_o(s_mem_w_o),
      .flags_q(s_flags_q), .saved_q(s_saved_q), .exec_cnt(s_exec_cnt), .skip_cnt(s_skip_cnt)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Advance one edge and settle 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; instr_valid = 1'b0; cond = 4'b0000; alu_flags = 4'b0000;
      flag_w = 2'b00; pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0; no_write = 1'b0;
      save = 1'b0; restore = 1'b0; sat_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;

      // Reset state
      check("rst_flags", flags_q, 16'h0);
      check("rst_saved", saved_q, 16'h0);
      check("rst_exec", exec_cnt, 16'h0);
      check("rst_skip", skip_cnt, 16'h0);
      cond = 4'b0001; pcs = 1'b1; reg_w = 1'b1; mem_w = 1'b1;
      #1;
      check("rst_ne_pass", cond_ex, 16'h1);
      check("idle_pcs_o", pcs_o, 16'h0);
      check("idle_reg_w_o", reg_w_o, 16'h0);
      check("idle_mem_w_o", mem_w_o, 16'h0);

      // EQ fails on zero flags, NE passes
      pcs = 1'b0; mem_w = 1'b0; instr_valid = 1'b1; cond = 4'b0000;
      #1;
      check("eq_fail", cond_ex, 16'h0);
      check("eq_reg_w_o", reg_w_o, 16'h0);
      step();
      check("skip_1", skip_cnt, 16'h1);
      check("exec_0", exec_cnt, 16'h0);
      cond = 4'b0001;
      #1;
      check("ne_pass", cond_ex, 16'h1);
      check("ne_reg_w_o", reg_w_o, 16'h1);
      step();
      check("exec_1", exec_cnt, 16'h1);

      // Flag write, then read back through conditions
      reg_w = 1'b0; cond = 4'b1110; alu_flags = 4'b0100; flag_w = 2'b11;
      step();                                            // exec=2
      check("wr_flags_0100", flags_q, 16'h4);
      flag_w = 2'b00; cond = 4'b0000;
      #1;
      check("eq_after_wr", cond_ex, 16'h1);
      cond = 4'b1000;
      #1;
      check("hi_after_wr", cond_ex, 16'h0);

      // Partial writes
      cond = 4'b1110; alu_flags = 4'b0000; flag_w = 2'b11;
      step();                                            // exec=3
      check("clr_flags", flags_q, 16'h0);
      alu_flags = 4'b1111; flag_w = 2'b10;
      step();                                            // exec=4
      check("part_nz", flags_q, 16'hC);
      alu_flags = 4'b0011; flag_w = 2'b01;
      step();                                            // exec=5
      check("part_cv", flags_q, 16'hF);

      // Failed instruction never writes flags or strobes
      alu_flags = 4'b0100; flag_w = 2'b11;
      step();                                            // exec=6
      check("set_0100", flags_q, 16'h4);
      cond = 4'b0001; alu_flags = 4'b1010; pcs = 1'b1; mem_w = 1'b1;
      #1;
      check("fail_cond", cond_ex, 16'h0);
      check("fail_mem_w_o", mem_w_o, 16'h0);
      check("fail_pcs_o", pcs_o, 16'h0);
      step();                                            // skip=2
      check("fail_hold", flags_q, 16'h4);
      check("skip_2", skip_cnt, 16'h2);
      cond = 4'b0000; flag_w = 2'b00;
      #1;
      check("pass_pcs_o", pcs_o, 16'h1);
      check("pass_mem_w_o", mem_w_o, 16'h1);
      step();                                            // exec=7
      pcs = 1'b0; mem_w = 1'b0;

      // Signed conditions with N=1,V=0
      cond = 4'b1110; alu_flags = 4'b1000; flag_w = 2'b11;
      step();                                            // exec=8
      check("set_1000", flags_q, 16'h8);
      flag_w = 2'b00;
      cond = 4'b1010; #1; check("ge_1000", cond_ex, 16'h0);
      cond = 4'b1011; #1; check("lt_1000", cond_ex, 16'h1);
      cond = 4'b1101; #1; check("le_1000", cond_ex, 16'h1);
      cond = 4'b1100; #1; check("gt_1000", cond_ex, 16'h0);

      // N=1,V=1
      cond = 4'b1110; alu_flags = 4'b1001; flag_w = 2'b11;
      step();                                            // exec=9
      check("set_1001", flags_q, 16'h9);
      flag_w = 2'b00;
      cond = 4'b1010; #1; check("ge_1001", cond_ex, 16'h1);
      cond = 4'b1100; #1; check("gt_1001", cond_ex, 16'h1);
      cond = 4'b1001; #1; check("ls_1001", cond_ex, 16'h1);
      cond = 4'b0000; alu_flags = 4'b0100;
      #1; check("no_bypass", cond_ex, 16'h0);
      cond = 4'b1110; reg_w = 1'b1; no_write = 1'b1;
      #1; check("cmp_reg_w_o", reg_w_o, 16'h0);
      reg_w = 1'b0; no_write = 1'b0;

      // Save with simultaneous update, then restore overriding a write
      alu_flags = 4'b0110; flag_w = 2'b11;
      step();                                            // exec=10
      check("set_0110", flags_q, 16'h6);
      save = 1'b1; alu_flags = 4'b1001;
      step();                                            // exec=11
      check("save_old", saved_q, 16'h6);
      check("save_upd", flags_q, 16'h9);
      save = 1'b0; restore = 1'b1; alu_flags = 4'b1111;
      step();                                            // exec=12
      check("restore", flags_q, 16'h6);
      restore = 1'b0; alu_flags = 4'b0011;
      step();                                            // exec=13
      check("set_0011", flags_q, 16'h3);
      save = 1'b1; restore = 1'b1; flag_w = 2'b00;
      step();                                            // exec=14
      check("swap_flags", flags_q, 16'h6);
      check("swap_saved", saved_q, 16'h3);
      save = 1'b0; restore = 1'b0;
      check("exec_14", exec_cnt, 16'd14);
      check("skip_still_2", skip_cnt, 16'h2);

      // Invalid slot: no count, no flag write
      instr_valid = 1'b0; alu_flags = 4'b1111; flag_w = 2'b11;
      step();
      check("idle_flags", flags_q, 16'h6);
      check("idle_exec", exec_cnt, 16'd14);
      check("idle_skip", skip_cnt, 16'h2);

      // Asynchronous reset mid-operation beats save/restore
      instr_valid = 1'b1; save = 1'b1; restore = 1'b1;
      #2 rst = 1'b1;
      #1;
      check("arst_flags", flags_q, 16'h0);
      check("arst_saved", saved_q, 16'h0);
      check("arst_exec", exec_cnt, 16'h0);
      step();
      check("arst_hold_saved", saved_q, 16'h0);
      instr_valid = 1'b0; save = 1'b0; restore = 1'b0; flag_w = 2'b00;
      rst = 1'b0;

      // Saturation on the CNT_W=2 instance
      check("sat_start", {14'd0, s_exec_cnt}, 16'h0);
      sat_valid = 1'b1;
      step(); step();
      check("sat_2", {14'd0, s_exec_cnt}, 16'h2);
      step(); step(); step();
      check("sat_3", {14'd0, s_exec_cnt}, 16'h3);
      check("sat_skip", {14'd0, s_skip_cnt}, 16'h0);
      sat_valid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
